// File: rtl/uart_rx_frame_timer_if.sv
// Control and status bundle between the UART receive FSM and the frame timer.
interface uart_rx_frame_timer_if #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
);
  logic                  start;
  logic                  abort;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  par_en;
  logic                  two_stop;
  logic                  busy;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [1:0]            phase;
  logic                  sample_stb;
  logic [1:0]            sample_idx;
  logic                  bit_done;
  logic                  frame_done;

  modport master (
    output start, abort, Prescale, par_en, two_stop,
    input  busy, edge_cnt, bit_cnt, phase, sample_stb, sample_idx, bit_done, frame_done
  );

  modport slave (
    input  start, abort, Prescale, par_en, two_stop,
    output busy, edge_cnt, bit_cnt, phase, sample_stb, sample_idx, bit_done, frame_done
  );
endinterface

// File: rtl/uart_rx_frame_timer.sv
// UART receive oversampling timer: edge/bit counters, frame phase, sample strobes.
// Define UART_RX_OVERSAMPLE3_EN for three strobes per bit (majority voting).
module uart_rx_frame_timer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = $clog2(DATA_WIDTH + 4)
) (
  input logic                  CLK,
  input logic                  RST,
  uart_rx_frame_timer_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  pe_q, pe_d;
  logic                  ts_q, ts_d;

  logic                  run;
  logic                  bit_end;
  logic                  frame_end;
  logic [BIT_CNT_W-1:0]  last_bit;
  logic [PRESCALE_W-1:0] half;

  assign run       = (state_q == StRun);
  assign half      = p_q >> 1;
  assign last_bit  = BIT_CNT_W'(DATA_WIDTH + 1) + BIT_CNT_W'(pe_q) + BIT_CNT_W'(ts_q);
  assign bit_end   = run && (edge_q == p_q - PRESCALE_W'(1));
  assign frame_end = bit_end && (bit_q == last_bit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= '0;
      pe_q    <= 1'b0;
      ts_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      pe_q    <= pe_d;
      ts_q    <= ts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    pe_d    = pe_q;
    ts_d    = ts_q;
    if (bus.abort) begin
      state_d = StIdle;
      edge_d  = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StRun;
            edge_d  = '0;
            bit_d   = '0;
            p_d     = bus.Prescale;
            pe_d    = bus.par_en;
            ts_d    = bus.two_stop;
          end
        end
        StRun: begin
          if (frame_end) begin
            edge_d = '0;
            bit_d  = '0;
            // A start on the last edge chains the next frame with no idle gap.
            if (bus.start) begin
              state_d = StRun;
              p_d     = bus.Prescale;
              pe_d    = bus.par_en;
              ts_d    = bus.two_stop;
            end else begin
              state_d = StIdle;
            end
          end else if (bit_end) begin
            edge_d = '0;
            bit_d  = bit_q + BIT_CNT_W'(1);
          end else begin
            edge_d = edge_q + PRESCALE_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          edge_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.busy       = run;
    bus.edge_cnt   = edge_q;
    bus.bit_cnt    = bit_q;
    bus.bit_done   = bit_end;
    bus.frame_done = frame_end;
    bus.sample_stb = 1'b0;
    bus.sample_idx = 2'd0;

    if (!run || bit_q == '0) begin
      bus.phase = 2'd0;
    end else if (bit_q <= BIT_CNT_W'(DATA_WIDTH)) begin
      bus.phase = 2'd1;
    end else if (pe_q && bit_q == BIT_CNT_W'(DATA_WIDTH + 1)) begin
      bus.phase = 2'd2;
    end else begin
      bus.phase = 2'd3;
    end

`ifdef UART_RX_OVERSAMPLE3_EN
    if (run) begin
      if (edge_q == half - PRESCALE_W'(1)) begin
        bus.sample_stb = 1'b1;
        bus.sample_idx = 2'd0;
      end else if (edge_q == half) begin
        bus.sample_stb = 1'b1;
        bus.sample_idx = 2'd1;
      end else if (edge_q == half + PRESCALE_W'(1)) begin
        bus.sample_stb = 1'b1;
        bus.sample_idx = 2'd2;
      end
    end
`else
    if (run && edge_q == half) begin
      bus.sample_stb = 1'b1;
      bus.sample_idx = 2'd1;
    end
`endif
  end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Self-checking bench for uart_rx_frame_timer (DATA_WIDTH=8, PRESCALE_W=6).
module tb_uart_rx_frame_timer;

  typedef struct {
    int p;
    int pe;
    int ts;
    int exp_cycles;
    int exp_bits;
  } vec_t;

`ifdef UART_RX_OVERSAMPLE3_EN
  localparam int StbPerBit = 3;
`else
  localparam int StbPerBit = 1;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_timer_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

  uart_rx_frame_timer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  function automatic logic [17:0] obs();
    return {bus.busy, bus.edge_cnt, bus.bit_cnt, bus.phase, bus.sample_stb,
            bus.sample_idx, bus.bit_done, bus.frame_done};
  endfunction

  // Expected outputs k cycles after the start edge, from plain division.
  function automatic logic [17:0] model(int k, int p, int pe, int ts);
    int n, e, b, h;
    logic [1:0] ph, idx;
    logic stb, bd, fd;
    n = 10 + pe + ts;
    if (k >= n * p) return 18'd0;
    e = k % p;
    b = k / p;
    h = p / 2;
    if (b == 0) ph = 2'd0;
    else if (b <= 8) ph = 2'd1;
    else if (pe == 1 && b == 9) ph = 2'd2;
    else ph = 2'd3;
`ifdef UART_RX_OVERSAMPLE3_EN
    stb = (e >= h - 1) && (e <= h + 1);
    idx = stb ? 2'(e - h + 1) : 2'd0;
`else
    stb = (e == h);
    idx = stb ? 2'd1 : 2'd0;
`endif
    bd = (e == p - 1);
    fd = bd && (b == n - 1);
    return {1'b1, 6'(e), 4'(b), ph, stb, idx, bd, fd};
  endfunction

  task automatic check_obs(input string name, input logic [17:0] want);
    logic [17:0] got;
    got = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%05h want=%05h", name, got, want);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input int p, input int pe, input int ts);
    bus.Prescale = 6'(p);
    bus.par_en   = pe[0];
    bus.two_stop = ts[0];
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    int   busy_n, bd_n, fd_n, stb_n, n;

    vecs[0] = '{p: 8,  pe: 0, ts: 0, exp_cycles: 80,  exp_bits: 10};
    vecs[1] = '{p: 16, pe: 1, ts: 1, exp_cycles: 192, exp_bits: 12};
    vecs[2] = '{p: 4,  pe: 1, ts: 0, exp_cycles: 44,  exp_bits: 11};
    vecs[3] = '{p: 62, pe: 0, ts: 1, exp_cycles: 682, exp_bits: 11};
    vecs[4] = '{p: 6,  pe: 0, ts: 1, exp_cycles: 66,  exp_bits: 11};

    RST          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.Prescale = 6'd8;
    bus.par_en   = 1'b0;
    bus.two_stop = 1'b0;
    repeat (2) step();
    check_obs("reset_state", 18'd0);
    RST = 1'b0;
    step();
    check_obs("idle_after_reset", 18'd0);

    // Whole frames; mid-frame config changes and a stray start must be ignored.
    foreach (vecs[v]) begin
      busy_n = 0; bd_n = 0; fd_n = 0; stb_n = 0;
      n = 10 + vecs[v].pe + vecs[v].ts;
      launch(vecs[v].p, vecs[v].pe, vecs[v].ts);
      for (int k = 0; k <= n * vecs[v].p; k++) begin
        check_obs($sformatf("trace v%0d k%0d", v, k), model(k, vecs[v].p, vecs[v].pe, vecs[v].ts));
        busy_n += int'(bus.busy);
        bd_n   += int'(bus.bit_done);
        fd_n   += int'(bus.frame_done);
        stb_n  += int'(bus.sample_stb);
        if (k == 3 * vecs[v].p + 1) begin
          bus.Prescale = (vecs[v].p == 8) ? 6'd16 : 6'd8;
          bus.par_en   = ~bus.par_en;
          bus.two_stop = ~bus.two_stop;
          bus.start    = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
        if (k != n * vecs[v].p) step();
      end
      check_val($sformatf("busy_cycles v%0d", v), busy_n, vecs[v].exp_cycles);
      check_val($sformatf("bit_done_cnt v%0d", v), bd_n, vecs[v].exp_bits);
      check_val($sformatf("frame_done_cnt v%0d", v), fd_n, 1);
      check_val($sformatf("stb_cnt v%0d", v), stb_n, vecs[v].exp_bits * StbPerBit);
    end

    // Abort at bit 4: idle next cycle, no frame_done.
    fd_n = 0;
    launch(8, 0, 0);
    for (int k = 0; k < 32; k++) begin
      fd_n += int'(bus.frame_done);
      step();
    end
    check_val("abort_at_bit4", int'(bus.bit_cnt), 4);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    fd_n += int'(bus.frame_done);
    check_obs("abort_cleared", 18'd0);
    check_val("abort_no_frame_done", fd_n, 0);

    // start with abort in idle stays idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_obs("start_abort_idle", 18'd0);
    step();
    check_obs("start_abort_idle2", 18'd0);

    // Back-to-back frames: restart on frame_done with new prescale.
    launch(4, 0, 0);
    repeat (39) step();
    check_obs("b2b_frame_done", model(39, 4, 0, 0));
    bus.Prescale = 6'd8;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    check_obs("b2b_restart", model(0, 8, 0, 0));
    repeat (8) step();
    check_obs("b2b_relatched", model(8, 8, 0, 0));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_obs("b2b_abort", 18'd0);

    // Asynchronous reset mid-frame at edge 5, bit 3.
    launch(8, 0, 0);
    repeat (29) step();
    check_obs("pre_rst", model(29, 8, 0, 0));
    #2;
    RST = 1'b1;
    #1;
    check_obs("async_rst", 18'd0);
    @(negedge CLK);
    RST = 1'b0;
    step();
    check_obs("post_rst_idle", 18'd0);
    step();
    check_obs("post_rst_idle2", 18'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_timer.md
# uart_rx_frame_timer

Oversampling timing engine for the UART receiver, and the parametrised successor of the receiver's edge/bit counter pair. It counts prescale edges within each bit and bits within a whole frame: start, DATA_WIDTH data bits, optional parity, and one or two stop bits. It also tracks frame phase and emits mid-bit sample strobes plus bit and frame completion pulses. It sits between the start-detect/FSM logic and the data sampler and deserializer.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- PRESCALE_W, 6: width of the prescale input and edge counter.
- BIT_CNT_W, $clog2(DATA_WIDTH+4): bit counter width (derived; do not override).

- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high; clears all state.
- start  in  1  frame-start pulse from start detection.
- abort  in  1  cancels the current frame (false start, glitch).
- Prescale  in  PRESCALE_W  oversampling ratio; must be even, 4..2^PRESCALE_W-2.
- par_en  in  1  parity bit present.
- two_stop  in  1  two stop bits when 1, one stop bit when 0.
- busy  out  1  frame in progress.
- edge_cnt  out  PRESCALE_W  edge index within the current bit, 0..P-1.
- bit_cnt  out  BIT_CNT_W  bit index within the frame; 0 is the start bit.
- phase  out  2  0 START, 1 DATA, 2 PARITY, 3 STOP.
- sample_stb  out  1  sample strobe for the data sampler.
- sample_idx  out  2  index of the current strobe within the bit: 0, 1, 2.
- bit_done  out  1  last edge of the current bit.
- frame_done  out  1  last edge of the last bit of the frame.

## Operation
- States: IDLE and RUN. Reset puts the block in IDLE.
- Reset and IDLE output values: busy=0, edge_cnt=0, bit_cnt=0, phase=0, sample_stb=0, sample_idx=0, bit_done=0, frame_done=0.
- Start of frame: in IDLE, `start`=1 with `abort`=0 moves to RUN.
  - Latches Prescale into P, par_en into PE and two_stop into TS.
  - Sets edge_cnt=0 and bit_cnt=0.
- Mid-frame changes to Prescale, par_en or two_stop have no effect on a running frame.
- Frame length N = 1 + DATA_WIDTH + PE + 1 + TS bits.
- Edge counting in RUN: edge_cnt increments each cycle and wraps to 0 after P-1. bit_cnt increments on each wrap.
- bit_done = RUN && edge_cnt==P-1 (combinational decode of registered state).
- frame_done = bit_done && bit_cnt==N-1.
  - On the frame_done edge the block returns to IDLE with counters cleared.
- phase is decoded from bit_cnt:
  - 0 gives START.
  - 1..DATA_WIDTH gives DATA.
  - DATA_WIDTH+1 gives PARITY when PE=1.
  - All remaining bits give STOP.
- Sample strobes: sample_stb=1 in RUN when edge_cnt==P/2.
  - sample_idx=1 at that point; see Configuration for the other strobes.
- Priority:
  - RST overrides everything.
  - abort overrides everything else: in any state it forces IDLE with all outputs at their reset values on the next edge.
  - In IDLE, start and abort in the same cycle leaves the block in IDLE.
- start in RUN is ignored, except on the frame_done cycle. There it re-enters RUN with counters 0 and re-latches configuration. This gives back-to-back frames with no idle gap.
- An asynchronous RST mid-frame clears everything immediately. No pulse is issued for the aborted frame.

## Timing
- start sampled at edge t gives busy=1, edge_cnt=0, bit_cnt=0 after edge t.
- Frame occupancy is exactly N*P cycles of busy=1.
- bit_done, frame_done and sample_stb are single-cycle pulses, valid in the same cycle as the counter value they decode. They carry zero latency from the counters.
- bit_done recurs every P cycles. frame_done asserts exactly once per completed frame.
- Counters never exceed P-1 and N-1. No wrap past N-1 is possible.

## Configuration
- Macro `UART_RX_OVERSAMPLE3_EN` defined: three strobes per bit, for majority voting.
  - Strobes at edge_cnt P/2-1, P/2 and P/2+1.
  - sample_idx is 0, 1 and 2 respectively.
- Macro not defined: a single strobe at P/2 with sample_idx=1.
  - sample_idx is constant 0 whenever sample_stb=0.
  - The logic for the extra strobes is not synthesised.

## Test plan
- DATA_WIDTH=8, P=8, PE=0, TS=0, start pulse -> busy for 80 cycles. 10 bit_done pulses. frame_done at bit_cnt=9, edge_cnt=7. phase sequence 0, 1×8, 3.
- P=16, PE=1, TS=1 -> busy for 192 cycles. phase=2 at bit_cnt=9, phase=3 at bit_cnt 10..11. Changing Prescale to 8 mid-frame has no effect.
- With `UART_RX_OVERSAMPLE3_EN`, P=8 -> sample_stb at edge_cnt 3, 4, 5 with sample_idx 0, 1, 2 in every bit. Without the macro -> one strobe at edge_cnt 4.
- abort at bit_cnt=4 -> next cycle busy=0 and all counters 0, with no frame_done. start together with abort in IDLE -> remains IDLE.
- start on the frame_done cycle -> next cycle busy=1, edge_cnt=0, bit_cnt=0, with no idle gap. A start pulse in mid-frame is ignored.
- RST asserted at edge_cnt=5, bit_cnt=3 -> outputs cleared asynchronously. After release, the block idles until the next start.
